// File: rtl/vga_scanout_pkg.sv
// Shared definitions for the VGA row scan-out path: state encoding and a
// clog2 helper that never returns less than one bit.
package vga_scanout_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } scan_state_t;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/row_elem_mux.sv
// Combinational selector returning element idx of a flattened row
// (element k at bits [WIDTH*(k+1)-1 : WIDTH*k]).
module row_elem_mux
  import vga_scanout_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SIZE  = 8
) (
  input  logic [WIDTH*SIZE-1:0]        row,
  input  logic [clog2_min1(SIZE)-1:0]  idx,
  output logic [WIDTH-1:0]             elem
);

  always_comb begin
    elem = '0;
    for (int unsigned k = 0; k < SIZE; k++) begin
      if (idx == k[clog2_min1(SIZE)-1:0]) elem = row[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/row_scanout.sv
// Captures a flattened row on start and streams its elements oldest-first,
// one per advance; define SCANOUT_REPEAT_EN to hold each element for REPEAT advances.
module row_scanout
  import vga_scanout_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SIZE   = 8,
  parameter int unsigned REPEAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH*SIZE-1:0] row_in,
  input  logic                  start,
  input  logic                  advance,
  output logic [WIDTH-1:0]      pixel_out,
  output logic                  pixel_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  refill_req
);

  localparam int unsigned IW = clog2_min1(SIZE);

  if (SIZE < 2 || REPEAT < 1) begin : g_param_check
    $error("row_scanout: SIZE must be >= 2 and REPEAT >= 1");
  end

  scan_state_t           r_state, w_state_d;
  logic [WIDTH*SIZE-1:0] r_row,   w_row_d;
  logic [IW-1:0]         r_idx,   w_idx_d;
  logic                  r_done,  w_done_d;
  logic                  r_refill, w_refill_d;
  logic                  w_elem_last;
  logic [WIDTH-1:0]      w_elem;

`ifdef SCANOUT_REPEAT_EN
  localparam int unsigned RW = clog2_min1(REPEAT);
  logic [RW-1:0] r_rep, w_rep_d;
  assign w_elem_last = (r_rep == RW'(REPEAT - 1));
`else
  assign w_elem_last = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_row    <= '0;
      r_idx    <= '0;
      r_done   <= 1'b0;
      r_refill <= 1'b0;
`ifdef SCANOUT_REPEAT_EN
      r_rep    <= '0;
`endif
    end else begin
      r_state  <= w_state_d;
      r_row    <= w_row_d;
      r_idx    <= w_idx_d;
      r_done   <= w_done_d;
      r_refill <= w_refill_d;
`ifdef SCANOUT_REPEAT_EN
      r_rep    <= w_rep_d;
`endif
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_row_d    = r_row;
    w_idx_d    = r_idx;
    w_done_d   = 1'b0;
    w_refill_d = 1'b0;
`ifdef SCANOUT_REPEAT_EN
    w_rep_d    = r_rep;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_row_d    = row_in;
          w_idx_d    = IW'(SIZE - 1);
          w_state_d  = ST_ACTIVE;
          w_refill_d = 1'b1;
`ifdef SCANOUT_REPEAT_EN
          w_rep_d    = '0;
`endif
        end
      end
      ST_ACTIVE: begin
        if (advance) begin
          if (w_elem_last) begin
`ifdef SCANOUT_REPEAT_EN
            w_rep_d = '0;
`endif
            if (r_idx == '0) begin
              w_done_d = 1'b1;
              // A start on the final advance chains straight into the next row.
              if (start) begin
                w_row_d    = row_in;
                w_idx_d    = IW'(SIZE - 1);
                w_refill_d = 1'b1;
              end else begin
                w_state_d  = ST_IDLE;
              end
            end else begin
              w_idx_d = r_idx - 1'b1;
            end
          end else begin
`ifdef SCANOUT_REPEAT_EN
            w_rep_d = r_rep + 1'b1;
`endif
          end
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  row_elem_mux #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE)
  ) u_mux (
    .row  (r_row),
    .idx  (r_idx),
    .elem (w_elem)
  );

  assign pixel_valid = (r_state == ST_ACTIVE);
  assign busy        = pixel_valid;
  assign pixel_out   = pixel_valid ? w_elem : '0;
  assign done        = r_done;
  assign refill_req  = r_refill;

endmodule

// File: tb/tb_row_scanout.sv
// Scoreboard bench for row_scanout (WIDTH=8, SIZE=4, REPEAT=2): a queue of
// expected pixel slots per captured row is compared against the DUT every cycle.
module tb_row_scanout;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned SIZE   = 4;
  localparam int unsigned REPEAT = 2;
`ifdef SCANOUT_REPEAT_EN
  localparam int unsigned REP = REPEAT;
`else
  localparam int unsigned REP = 1;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [WIDTH*SIZE-1:0] row_in = '0;
  logic                  start = 1'b0;
  logic                  advance = 1'b0;
  logic [WIDTH-1:0]      pixel_out;
  logic                  pixel_valid, busy, done, refill_req;

  row_scanout #(.WIDTH(WIDTH), .SIZE(SIZE), .REPEAT(REPEAT)) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .start(start), .advance(advance),
    .pixel_out(pixel_out), .pixel_valid(pixel_valid), .busy(busy),
    .done(done), .refill_req(refill_req)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  // Reference model: remaining pixel slots of the current scan, oldest first.
  logic [WIDTH-1:0] exp_q[$];
  bit exp_done = 1'b0;
  bit exp_refill = 1'b0;

  task automatic load_row(input logic [WIDTH*SIZE-1:0] r);
    logic [WIDTH*SIZE-1:0] tmp;
    tmp = r;
    for (int e = SIZE - 1; e >= 0; e--)
      for (int k = 0; k < REP; k++)
        exp_q.push_back(tmp[e*WIDTH +: WIDTH]);
  endtask

  always @(posedge clk) begin
    exp_done   = 1'b0;
    exp_refill = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      if (start) begin
        load_row(row_in);
        exp_refill = 1'b1;
      end
    end else if (advance) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        exp_done = 1'b1;
        if (start) begin
          load_row(row_in);
          exp_refill = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("pixel_valid", 32'(pixel_valid), 32'(exp_q.size() != 0));
      chk("busy",        32'(busy),        32'(exp_q.size() != 0));
      chk("pixel_out",   32'(pixel_out),   (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
      chk("done",        32'(done),        32'(exp_done));
      chk("refill_req",  32'(refill_req),  32'(exp_refill));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // One scan: advance every `gap` cycles; optional chained start on the final
  // advance, junk start after `junk_at` advances, reset after `rst_at` advances.
  task automatic scan(input logic [31:0] row, input int gap, input bit b2b,
                      input int junk_at, input int rst_at);
    int n;
    int t;
    bit chained;
    n = 0;
    chained = 1'b0;
    start = 1'b1; row_in = row; advance = (gap == 1);
    cyc();
    start = 1'b0; row_in = $urandom;
    for (t = 0; t < 400 && exp_q.size() != 0; t++) begin
      advance = ((t % gap) == gap - 1);
      start = 1'b0;
      rst_n = 1'b1;
      if (rst_at > 0 && n == rst_at) begin
        rst_n = 1'b0;
        advance = 1'b0;
      end
      if (advance && b2b && !chained && exp_q.size() == 1) begin
        start = 1'b1; row_in = 32'hAABBCCDD; chained = 1'b1;
      end else if (junk_at > 0 && n == junk_at && exp_q.size() > 1) begin
        start = 1'b1; row_in = 32'hFFFFFFFF;
      end
      if (advance) n++;
      cyc();
    end
    start = 1'b0; advance = 1'b0; rst_n = 1'b1;
    if (exp_q.size() != 0) chk("scan_timeout", 32'(exp_q.size()), 32'd0);
    cyc();
  endtask

  initial begin
    mon_en = 1'b1;
    repeat (3) cyc();
    rst_n = 1'b1;
    advance = 1'b1;
    repeat (3) cyc();
    advance = 1'b0;
    cyc();
    scan(32'h11223344, 1, 1'b0, 0, 0);
    scan(32'h11223344, 3, 1'b0, 0, 0);
    scan(32'h44332211, 1, 1'b1, 0, 0);
    scan(32'h11223344, 2, 1'b0, 3, 0);
    scan(32'h11223344, 1, 1'b0, 0, 3);
    repeat (500) begin
      rst_n   = ($urandom_range(0, 63) != 0);
      start   = ($urandom_range(0, 7) == 0);
      advance = $urandom_range(0, 1);
      row_in  = $urandom;
      cyc();
    end
    rst_n = 1'b1; start = 1'b0; advance = 1'b1;
    repeat (20) cyc();
    advance = 1'b0;
    cyc();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/row_scanout.md
# row_scanout

Downstream consumer of the row shift register in the VGA test path. On a start strobe it captures one full flattened row of SIZE elements, each WIDTH bits wide. It then emits the elements one at a time on a pixel stream, paced by an advance enable from the VGA timing generator. It optionally replicates each element for horizontal scaling, and it signals upstream when the row has been captured so the shift register can begin refilling.

## Interface
- WIDTH, 8: bits per element/pixel.
- SIZE, 8: elements per row; must be >= 2.
- REPEAT, 2: advances per element when SCANOUT_REPEAT_EN is defined; must be >= 1.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- row_in  in  WIDTH*SIZE  flattened row.
  - Element k occupies bits [WIDTH*(k+1)-1 : WIDTH*k].
  - Element SIZE-1 (MSBs) is the oldest element shifted in.
- start  in  1  capture row_in and begin a scan. Ignored while busy, except on the final-advance cycle.
- advance  in  1  pixel-tick enable; consumes one repeat slot while active.
- pixel_out  out  WIDTH  current element; 0 when idle.
- pixel_valid  out  1  high while ACTIVE.
- busy  out  1  same as pixel_valid; kept separate for control logic.
- done  out  1  one-cycle pulse after the last element's last repeat is consumed.
- refill_req  out  1  one-cycle pulse the cycle after a row is captured.

## Operation
- States:
  - IDLE (reset state).
  - ACTIVE.
- Internal registers:
  - row_q: WIDTH*SIZE holding register.
  - idx: $clog2(SIZE) bits.
  - rep: max(1, $clog2(REPEAT)) bits.
- IDLE with start=1:
  - row_q <= row_in, idx <= SIZE-1, rep <= 0.
  - Go to ACTIVE; refill_req pulses next cycle.
- ACTIVE with advance=1:
  - If rep == REPEAT-1: rep <= 0.
    - If idx == 0: scan complete, go to IDLE, done pulses next cycle.
    - Else idx <= idx-1.
  - Else rep <= rep+1.
- ACTIVE with advance=0: all state holds. No timeout.
- Emission order is element SIZE-1 down to element 0 (oldest first).
- pixel_out = row_q element idx when ACTIVE, else 0.
  - Combinational from registers only; no path from row_in.
- Boundary conditions:
  - start on the same cycle as the final advance: reload row_q from row_in, idx <= SIZE-1, rep <= 0, stay ACTIVE. done and refill_req both pulse next cycle. pixel_valid has no gap.
  - start in ACTIVE other than on the final advance: ignored. row_q is unchanged.
  - advance in IDLE: ignored.
  - start and advance together in IDLE: capture only; the advance is not consumed.
  - rst_n low at any time, including mid-scan: next edge forces IDLE, row_q=0, idx=0, rep=0, done=0, refill_req=0.
- Reset values:
  - pixel_out=0, pixel_valid=0, busy=0, done=0, refill_req=0.

## Timing
- Capture latency: start sampled at edge N. pixel_valid=1, pixel_out=element SIZE-1 and refill_req=1 are all visible after edge N.
- Each advance sampled at edge M updates pixel_out after edge M.
- A scan consumes exactly SIZE*REPEAT advances (SIZE without the macro).
- done and busy=0 appear after the edge that samples the final advance.
- With advance held high, the minimum start-to-done time is SIZE*REPEAT+1 cycles.

## Configuration
- SCANOUT_REPEAT_EN defined:
  - Each element is held for REPEAT advances.
- SCANOUT_REPEAT_EN undefined:
  - The rep register is removed and REPEAT is ignored.
  - Every advance steps idx, so a scan takes SIZE advances.

## Structure
- Shared package vga_scanout_pkg holds:
  - The state encoding localparams ST_IDLE=1'b0 and ST_ACTIVE=1'b1.
  - A clog2 helper function with a minimum result of 1.
- Sub-module row_elem_mux selects element idx from the flattened row_q.
  - Parameters WIDTH and SIZE.
  - Purely combinational.
  - Reusable by other row consumers.

## Test plan
All scenarios use WIDTH=8, SIZE=4, REPEAT=2.
- Basic scan, macro defined:
  - Stimulus: row_in=32'h11223344, start one cycle, advance held high.
  - Required: pixel_out = 11,11,22,22,33,33,44,44; then done one cycle, pixel_out=0, busy=0.
  - Required: refill_req high the cycle after the start edge.
- Advance gaps:
  - Stimulus: advance high every third cycle.
  - Required: each value holds until consumed; still exactly 8 advances to done.
- Back-to-back:
  - Stimulus: start with row_in=32'hAABBCCDD on the 8th advance cycle.
  - Required: pixel_out goes 44 -> AA with no invalid cycle; done and refill_req pulse together.
- Ignored start:
  - Stimulus: start with row_in=32'hFFFFFFFF mid-scan.
  - Required: the output sequence is unchanged.
- Reset mid-scan:
  - Stimulus: rst_n low after the 3rd advance.
  - Required: next cycle all outputs are 0, busy=0, and no done pulse.
- Macro undefined:
  - Stimulus: the basic scan.
  - Required: pixel_out = 11,22,33,44; done after the 4th advance.
